// File: rtl/kmc_pkg.sv
// kmc_pkg
//   Shared definitions for the KMC11 control RAM (CRAM) maintenance path.
//   The CRAM width/depth constants are also used by the microsequencer CRAM
//   mux, so both sides of the cramSEL steering agree on the word geometry.
//   Contents:
//     CRAM_ADDR_WIDTH  CRAM address bits (1K words)
//     CRAM_DATA_WIDTH  CRAM word width
//     ldr_state_t      loader FSM states
package kmc_pkg;

  localparam int CRAM_ADDR_WIDTH = 10;
  localparam int CRAM_DATA_WIDTH = 16;

  // Loader cycle states. REJ is a one-cycle completion for refused
  // requests and never touches the CRAM.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RDWAIT  = 3'd2,
    CHECK   = 3'd3,
    CAPTURE = 3'd4,
    REJ     = 3'd5,
    DONE    = 3'd6
  } ldr_state_t;

endpackage

// File: rtl/kmc_cram_ldr.sv
// kmc_cram_ldr
//   Host-side maintenance loader/reader for the KMC11 1K x 16 control RAM.
//   Runs one write, write-verify or read cycle per host request while the
//   microprocessor is halted, and owns the CRAM address/data/WE path for the
//   duration of that cycle (cramSEL).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   kmcINIT         synchronous initialize (MCLR)
//   kmcRUN          microprocessor running; loader access is illegal while high
//   hostWR/hostRD   write (CRAMWR) / read (ROMO) request pulses
//   hostAUTOINC     use the internal pointer instead of hostADDR
//   hostADDR/DATA   CRAM address (SEL4) and write data (SEL6)
//   hostRDATA       read-back data, held until the next read or INIT
//   hostPTR         last used address + 1
//   hostBUSY        operation in progress
//   hostDONE        one-cycle completion pulse
//   hostERR         sticky error (reject, verify miscompare, abort)
//   cramSEL         steers the CRAM mux to this loader
//   cramADDR/DATO   CRAM address and write data
//   cramWE          CRAM write enable
//   cramDATI        CRAM read data, valid the cycle after the address
module kmc_cram_ldr
  import kmc_pkg::*;
#(
  parameter int ADDR_WIDTH = CRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = CRAM_DATA_WIDTH,
  parameter bit VERIFY     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  kmcINIT,
  input  logic                  kmcRUN,
  input  logic                  hostWR,
  input  logic                  hostRD,
  input  logic                  hostAUTOINC,
  input  logic [ADDR_WIDTH-1:0] hostADDR,
  input  logic [DATA_WIDTH-1:0] hostDATA,
  output logic [DATA_WIDTH-1:0] hostRDATA,
  output logic [ADDR_WIDTH-1:0] hostPTR,
  output logic                  hostBUSY,
  output logic                  hostDONE,
  output logic                  hostERR,
  output logic                  cramSEL,
  output logic [ADDR_WIDTH-1:0] cramADDR,
  output logic [DATA_WIDTH-1:0] cramDATO,
  output logic                  cramWE,
  input  logic [DATA_WIDTH-1:0] cramDATI
);

  ldr_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  wr_q;
  logic                  ok_q;
  logic                  err_q;

  logic active;
  logic accept;
  logic reject;
  logic abort;

  // State register. INIT behaves like reset but waits for the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (kmcINIT) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and all CRAM/host strobes. The CRAM-owning states are
  // grouped as "active"; only those can be aborted by the micro starting up,
  // and an abort jumps straight to DONE so SEL/WE fall on that same edge.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    abort     = 1'b0;
    active    = (state == WRITE) || (state == RDWAIT) ||
                (state == CHECK) || (state == CAPTURE);

    case (state)
      IDLE: begin
        if (hostWR || hostRD) begin
          if (kmcRUN || (hostWR && hostRD)) begin
            reject    = 1'b1;
            state_nxt = REJ;
          end else begin
            accept    = 1'b1;
            state_nxt = hostWR ? WRITE : RDWAIT;
          end
        end
      end
      WRITE:   state_nxt = VERIFY ? RDWAIT : DONE;
      RDWAIT:  state_nxt = wr_q ? CHECK : CAPTURE;
      CHECK:   state_nxt = DONE;
      CAPTURE: state_nxt = DONE;
      REJ:     state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (active && kmcRUN) begin
      abort     = 1'b1;
      state_nxt = DONE;
    end

    hostBUSY = (state != IDLE) && (state != REJ);
    hostDONE = (state == DONE) || (state == REJ);
    cramSEL  = active;
    cramWE   = (state == WRITE);
    cramADDR = active ? addr_q : '0;
    cramDATO = active ? data_q : '0;
  end

  // Request latches, pointer, read-back register and the sticky error.
  // ok_q remembers whether the cycle ran to completion, so DONE only moves
  // the pointer for operations that actually reached the CRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (kmcINIT) begin
      addr_q  <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= hostAUTOINC ? ptr_q : hostADDR;
        data_q <= hostDATA;
        wr_q   <= hostWR;
        ok_q   <= 1'b1;
        err_q  <= 1'b0;
      end
      if (reject) begin
        err_q <= 1'b1;
      end
      if (abort) begin
        ok_q  <= 1'b0;
        err_q <= 1'b1;
      end else begin
        if ((state == CHECK) && (cramDATI != data_q)) begin
          err_q <= 1'b1;
        end
        if (state == CAPTURE) begin
          rdata_q <= cramDATI;
        end
      end
      if ((state == DONE) && ok_q) begin
        ptr_q <= addr_q + 1'b1;
      end
    end
  end

  assign hostRDATA = rdata_q;
  assign hostPTR   = ptr_q;
  assign hostERR   = err_q;

endmodule

// File: tb/tb_kmc_cram_ldr.sv
// tb_kmc_cram_ldr
//   Directed + randomized bench for the CRAM loader. A synchronous RAM model
//   (with an optional stuck-at-0 mask) sits on the cram* port; a reference
//   model tracks the expected CRAM contents, pointer, error and read-back
//   register purely from the operation sequence.
module tb_kmc_cram_ldr;

  logic        clk;
  logic        rst_n;
  logic        kmcINIT;
  logic        kmcRUN;
  logic        hostWR;
  logic        hostRD;
  logic        hostAUTOINC;
  logic [9:0]  hostADDR;
  logic [15:0] hostDATA;
  logic [15:0] hostRDATA;
  logic [9:0]  hostPTR;
  logic        hostBUSY;
  logic        hostDONE;
  logic        hostERR;
  logic        cramSEL;
  logic [9:0]  cramADDR;
  logic [15:0] cramDATO;
  logic        cramWE;
  logic [15:0] cramDATI;

  int vectors = 0;
  int miscompares = 0;

  // RAM model, backdoor port and write-address log
  logic [15:0] mem [1024];
  logic        bdWE;
  logic [9:0]  bdAddr;
  logic [15:0] bdData;
  logic [15:0] stuckMask;
  logic [9:0]  weAddrQ [$];

  // Reference model state
  logic [15:0] refMem [1024];
  logic [9:0]  expPtr;
  logic        expErr;
  logic [15:0] expRdata;

  kmc_cram_ldr dut (
    .clk(clk), .rst_n(rst_n), .kmcINIT(kmcINIT), .kmcRUN(kmcRUN),
    .hostWR(hostWR), .hostRD(hostRD), .hostAUTOINC(hostAUTOINC),
    .hostADDR(hostADDR), .hostDATA(hostDATA), .hostRDATA(hostRDATA),
    .hostPTR(hostPTR), .hostBUSY(hostBUSY), .hostDONE(hostDONE),
    .hostERR(hostERR), .cramSEL(cramSEL), .cramADDR(cramADDR),
    .cramDATO(cramDATO), .cramWE(cramWE), .cramDATI(cramDATI)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous CRAM: read-first, data valid the cycle after the address.
  always @(posedge clk) begin
    if (bdWE) begin
      mem[bdAddr] <= bdData;
    end else if (cramWE) begin
      mem[cramADDR] <= cramDATO & ~stuckMask;
    end
    cramDATI <= mem[cramADDR];
  end

  always @(posedge clk) begin
    if (cramWE) weAddrQ.push_back(cramADDR);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request (cycle 0), then samples each following cycle at the
  // falling edge until DONE, bounded. Ends one cycle after DONE.
  task automatic applyStimulus(input logic wr, input logic rd, input logic ai,
                               input logic [9:0] addr, input logic [15:0] data,
                               input logic poke, output int doneCyc,
                               output int weMask, output logic errC1,
                               output logic busyC1);
    @(negedge clk);
    hostWR = wr; hostRD = rd; hostAUTOINC = ai; hostADDR = addr; hostDATA = data;
    @(negedge clk);
    hostWR = 1'b0; hostRD = 1'b0; hostAUTOINC = 1'b0;
    doneCyc = 0;
    weMask = 0;
    errC1 = hostERR;
    busyC1 = hostBUSY;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      if (cramWE) weMask |= (1 << c);
      if (poke && c == 2) hostRD = 1'b1;
      if (poke && c == 3) hostRD = 1'b0;
      if (hostDONE) begin
        doneCyc = c;
        break;
      end
    end
    hostRD = 1'b0;
    @(negedge clk);
  endtask

  // One complete operation: drive it, advance the reference model, compare.
  task automatic runOp(input string tag, input logic wr, input logic rd, input logic ai,
                       input logic [9:0] addr, input logic [15:0] data, input logic poke);
    int doneCyc, weMask, expDone, expWe, weBefore;
    logic errC1, busyC1, bad;
    logic [9:0] effA;
    logic [15:0] stored;
    bad = kmcRUN || (wr && rd);
    effA = ai ? expPtr : addr;
    weBefore = weAddrQ.size();
    applyStimulus(wr, rd, ai, addr, data, poke, doneCyc, weMask, errC1, busyC1);
    if (bad) begin
      expErr = 1'b1; expDone = 1; expWe = 0;
    end else begin
      if (wr) begin
        stored = data & ~stuckMask;
        refMem[effA] = stored;
        expErr = (stored != data);
        expDone = 4;
        expWe = 2;
      end else begin
        expRdata = refMem[effA];
        expErr = 1'b0;
        expDone = 3;
        expWe = 0;
      end
      expPtr = 10'((int'(effA) + 1) % 1024);
    end
    checkOutput({tag, ".doneCycle"}, doneCyc, expDone);
    checkOutput({tag, ".weCycles"}, weMask, expWe);
    checkOutput({tag, ".errC1"}, {31'd0, errC1}, {31'd0, bad});
    checkOutput({tag, ".busyC1"}, {31'd0, busyC1}, {31'd0, !bad});
    checkOutput({tag, ".err"}, {31'd0, hostERR}, {31'd0, expErr});
    checkOutput({tag, ".ptr"}, {22'd0, hostPTR}, {22'd0, expPtr});
    checkOutput({tag, ".rdata"}, {16'd0, hostRDATA}, {16'd0, expRdata});
    checkOutput({tag, ".busyAfter"}, {31'd0, hostBUSY}, 32'd0);
    checkOutput({tag, ".weCount"}, weAddrQ.size() - weBefore, (!bad && wr) ? 1 : 0);
    if (!bad && wr && weAddrQ.size() > weBefore) begin
      checkOutput({tag, ".weAddr"}, {22'd0, weAddrQ[weBefore]}, {22'd0, effA});
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".rdata"}, {16'd0, hostRDATA}, 32'd0);
    checkOutput({tag, ".ptr"}, {22'd0, hostPTR}, 32'd0);
    checkOutput({tag, ".busy"}, {31'd0, hostBUSY}, 32'd0);
    checkOutput({tag, ".done"}, {31'd0, hostDONE}, 32'd0);
    checkOutput({tag, ".err"}, {31'd0, hostERR}, 32'd0);
    checkOutput({tag, ".sel"}, {31'd0, cramSEL}, 32'd0);
    checkOutput({tag, ".addr"}, {22'd0, cramADDR}, 32'd0);
    checkOutput({tag, ".dato"}, {16'd0, cramDATO}, 32'd0);
    checkOutput({tag, ".we"}, {31'd0, cramWE}, 32'd0);
  endtask

  initial begin
    logic [9:0]  a, a2;
    logic [15:0] d;
    int weBase;

    rst_n = 1'b0; kmcINIT = 1'b0; kmcRUN = 1'b0;
    hostWR = 1'b0; hostRD = 1'b0; hostAUTOINC = 1'b0; hostADDR = '0; hostDATA = '0;
    stuckMask = '0; bdWE = 1'b0; bdAddr = '0; bdData = '0;
    expPtr = '0; expErr = 1'b0; expRdata = '0;

    // Preload the whole CRAM with random contents through the backdoor.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      bdWE = 1'b1; bdAddr = 10'(i); bdData = 16'($urandom);
      refMem[i] = bdData;
    end
    @(negedge clk);
    bdWE = 1'b0;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Write with verify at the top address; pointer wraps to 0.
    runOp("t1.wr", 1'b1, 1'b0, 1'b0, 10'h3FF, 16'h1234, 1'b0);
    runOp("t1.rdback", 1'b0, 1'b1, 1'b0, 10'h3FF, 16'h0, 1'b0);

    // Plain read of a known location.
    @(negedge clk);
    bdWE = 1'b1; bdAddr = 10'h005; bdData = 16'hBEEF;
    @(negedge clk);
    bdWE = 1'b0;
    refMem[5] = 16'hBEEF;
    runOp("t2.rd", 1'b0, 1'b1, 1'b0, 10'h005, 16'h0, 1'b0);
    checkOutput("t2.beef", {16'd0, hostRDATA}, 32'h0000BEEF);

    // Stuck-at-0 on bit 3 makes the verify fail; next good write clears ERR.
    stuckMask = 16'h0008;
    a = 10'($urandom_range(0, 1023));
    runOp("t3.stuck", 1'b1, 1'b0, 1'b0, a, 16'h0008, 1'b0);
    checkOutput("t3.errSet", {31'd0, hostERR}, 32'd1);
    stuckMask = 16'h0000;
    runOp("t3.good", 1'b1, 1'b0, 1'b0, 10'($urandom), 16'($urandom), 1'b0);

    // Rejects: micro running, then WR and RD together.
    kmcRUN = 1'b1;
    runOp("t4.run", 1'b1, 1'b0, 1'b0, 10'($urandom), 16'($urandom), 1'b0);
    kmcRUN = 1'b0;
    runOp("t4.clear", 1'b0, 1'b1, 1'b0, 10'($urandom), 16'h0, 1'b0);
    runOp("t4.both", 1'b1, 1'b1, 1'b0, 10'($urandom), 16'($urandom), 1'b0);

    // Autoincrement burst across the wrap, with a stray read poked mid-cycle.
    runOp("t5.setup", 1'b1, 1'b0, 1'b0, 10'd1021, 16'($urandom), 1'b0);
    weBase = weAddrQ.size();
    for (int k = 0; k < 4; k++) begin
      runOp("t5.burst", 1'b1, 1'b0, 1'b1, 10'($urandom), 16'($urandom), k == 0);
    end
    for (int k = 0; k < 4; k++) begin
      checkOutput("t5.burstAddr", (weAddrQ.size() > weBase + k) ? {22'd0, weAddrQ[weBase + k]} : 32'hFFFF,
                  (1022 + k) % 1024);
    end
    for (int k = 0; k < 4; k++) begin
      runOp("t5.rdback", 1'b0, 1'b1, 1'b0, 10'((1022 + k) % 1024), 16'h0, 1'b0);
    end

    // Random mix of reads and writes, some using the pointer.
    for (int k = 0; k < 12; k++) begin
      logic w, ai;
      w = 1'($urandom_range(0, 1));
      ai = ($urandom_range(0, 3) == 0);
      runOp("mix", w, !w, ai, 10'($urandom), 16'($urandom), 1'b0);
    end

    // Abort: micro starts while the read is waiting on the RAM.
    a = 10'($urandom);
    @(negedge clk);
    hostRD = 1'b1; hostADDR = a;
    @(negedge clk);
    hostRD = 1'b0;
    checkOutput("t6.selBefore", {31'd0, cramSEL}, 32'd1);
    kmcRUN = 1'b1;
    @(negedge clk);
    checkOutput("t6.selDrop", {31'd0, cramSEL}, 32'd0);
    checkOutput("t6.weDrop", {31'd0, cramWE}, 32'd0);
    checkOutput("t6.done", {31'd0, hostDONE}, 32'd1);
    checkOutput("t6.err", {31'd0, hostERR}, 32'd1);
    kmcRUN = 1'b0;
    expErr = 1'b1;
    @(negedge clk);
    checkOutput("t6.ptr", {22'd0, hostPTR}, {22'd0, expPtr});
    checkOutput("t6.rdata", {16'd0, hostRDATA}, {16'd0, expRdata});
    checkOutput("t6.idle", {31'd0, hostBUSY}, 32'd0);

    // Asynchronous reset in the middle of a write.
    @(negedge clk);
    hostWR = 1'b1; hostADDR = 10'($urandom); hostDATA = 16'($urandom);
    @(negedge clk);
    hostWR = 1'b0;
    checkOutput("t6.weLive", {31'd0, cramWE}, 32'd1);
    #1 rst_n = 1'b0;
    #1 checkAllZero("t6.async");
    @(negedge clk);
    rst_n = 1'b1;
    expPtr = '0; expErr = 1'b0; expRdata = '0;

    // INIT clears loader state but leaves CRAM contents alone.
    a2 = 10'($urandom_range(1, 1022));
    d = 16'($urandom);
    runOp("t7.wr", 1'b1, 1'b0, 1'b0, a2, d, 1'b0);
    runOp("t7.rd", 1'b0, 1'b1, 1'b0, 10'($urandom), 16'h0, 1'b0);
    kmcRUN = 1'b1;
    runOp("t7.rej", 1'b1, 1'b0, 1'b0, 10'($urandom), 16'h0, 1'b0);
    kmcRUN = 1'b0;
    @(negedge clk);
    kmcINIT = 1'b1;
    @(negedge clk);
    kmcINIT = 1'b0;
    expPtr = '0; expErr = 1'b0; expRdata = '0;
    checkAllZero("t7.init");
    runOp("t7.keep", 1'b0, 1'b1, 1'b0, a2, 16'h0, 1'b0);
    checkOutput("t7.kept", {16'd0, hostRDATA}, {16'd0, d});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
